// File: rtl/ldst_pkg.sv
// Shared types and default widths for the load/store sequencer.
package ldst_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_AW_DEF = 5;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_e;
endpackage

// File: rtl/soma_endereco.sv
// Unsigned address adder: modular sum plus carry out for wrap reporting.
module soma_endereco #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/unidade_ldst.sv
// Load/store sequencer: one command at a time, base+offset addressing,
// moves a word between register file and data memory, pulses done.
module unidade_ldst
  import ldst_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [REG_AW-1:0] cmd_base,
  input  logic [REG_AW-1:0] cmd_reg,
  input  logic [ADDR_W-1:0] cmd_off,
  output logic              done,
  output logic              done_wrap,
  output logic [REG_AW-1:0] reg_ra,
  output logic [REG_AW-1:0] reg_rb,
  input  logic [DATA_W-1:0] reg_douta,
  input  logic [DATA_W-1:0] reg_doutb,
  output logic [REG_AW-1:0] reg_rw,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_din,
  output logic [ADDR_W-1:0] mem_ads,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  state_e              state_q;
  logic                op_q;
  logic [REG_AW-1:0]   reg_q;
  logic [ADDR_W-1:0]   off_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wrap_q;
  logic [DATA_W-1:0]   sdata_q;

  logic                cmd_ready_q, done_q, done_wrap_q, reg_we_q, mem_we_q;
  logic [REG_AW-1:0]   reg_ra_q, reg_rb_q, reg_rw_q;
  logic [ADDR_W-1:0]   mem_ads_q;
  logic [DATA_W-1:0]   mem_din_q;

  logic [ADDR_W-1:0]   sum;
  logic                carry;

  // Only the low ADDR_W bits of the base register form the address.
  logic unused_base_hi;
  assign unused_base_hi = ^reg_douta[DATA_W-1:ADDR_W];

  soma_endereco #(.W(ADDR_W)) u_soma (
    .a     (reg_douta[ADDR_W-1:0]),
    .b     (off_q),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      reg_q       <= '0;
      off_q       <= '0;
      addr_q      <= '0;
      wrap_q      <= 1'b0;
      sdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      done_wrap_q <= 1'b0;
      reg_ra_q    <= '0;
      reg_rb_q    <= '0;
      reg_rw_q    <= '0;
      reg_we_q    <= 1'b0;
      mem_ads_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_din_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (cmd_valid && cmd_ready_q) begin
          op_q        <= cmd_op;
          reg_q       <= cmd_reg;
          off_q       <= cmd_off;
          reg_ra_q    <= cmd_base;
          reg_rb_q    <= cmd_reg;
          cmd_ready_q <= 1'b0;
          state_q     <= ADDR;
        end
        ADDR: begin
          addr_q    <= sum;
          wrap_q    <= carry;
          sdata_q   <= reg_doutb;
          reg_ra_q  <= '0;
          reg_rb_q  <= '0;
          mem_ads_q <= sum;
          if (op_q == OP_STORE) begin
            mem_we_q  <= 1'b1;
            mem_din_q <= reg_doutb;
          end
          state_q <= MEM;
        end
        MEM: begin
          mem_we_q  <= 1'b0;
          mem_din_q <= '0;
          if (op_q == OP_STORE) begin
            mem_ads_q   <= '0;
            done_q      <= 1'b1;
            done_wrap_q <= wrap_q;
            state_q     <= DONE;
          end else begin
            // Address stays up so the memory's registered read lands in WB.
            mem_ads_q <= addr_q;
            reg_rw_q  <= reg_q;
            reg_we_q  <= 1'b1;
            state_q   <= WB;
          end
        end
        WB: begin
          reg_we_q    <= 1'b0;
          reg_rw_q    <= '0;
          mem_ads_q   <= '0;
          done_q      <= 1'b1;
          done_wrap_q <= wrap_q;
          state_q     <= DONE;
        end
        DONE: begin
          done_q      <= 1'b0;
          done_wrap_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign done_wrap = done_wrap_q;
  assign reg_ra    = reg_ra_q;
  assign reg_rb    = reg_rb_q;
  assign reg_rw    = reg_rw_q;
  assign reg_we    = reg_we_q;
  assign mem_ads   = mem_ads_q;
  assign mem_we    = mem_we_q;
  assign mem_din   = mem_din_q;
  // Read data only becomes valid during WB, so it passes straight through.
  assign reg_din   = (state_q == WB) ? mem_dout : '0;
endmodule

// File: tb/tb_unidade_ldst.sv
// Bench for unidade_ldst: models register file and memory, scoreboards commands.
module tb_unidade_ldst;
  localparam int DW = 64, AW = 5, RW = 5;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [RW-1:0] cmd_base = '0, cmd_reg = '0;
  logic [AW-1:0] cmd_off = '0;
  logic          cmd_ready, done, done_wrap, reg_we, mem_we;
  logic [RW-1:0] reg_ra, reg_rb, reg_rw;
  logic [AW-1:0] mem_ads;
  logic [DW-1:0] reg_douta, reg_doutb, reg_din, mem_din, mem_dout;

  always #5 clk = ~clk;

  unidade_ldst dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_reg(cmd_reg), .cmd_off(cmd_off),
    .done(done), .done_wrap(done_wrap), .reg_ra(reg_ra), .reg_rb(reg_rb),
    .reg_douta(reg_douta), .reg_doutb(reg_doutb), .reg_rw(reg_rw), .reg_we(reg_we),
    .reg_din(reg_din), .mem_ads(mem_ads), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Register file and memory models; bench presets go through a backdoor port.
  logic [DW-1:0] regs [32];
  logic [DW-1:0] mem  [32];
  logic          bd_we = 1'b0, bd_mem = 1'b0;
  logic [4:0]    bd_idx = '0;
  logic [DW-1:0] bd_data = '0;
  int            cyc = 0;

  initial mem_dout = '0;
  assign reg_douta = regs[reg_ra];
  assign reg_doutb = regs[reg_rb];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_dout <= mem[mem_ads];
    if (bd_we) begin
      if (bd_mem) mem[bd_idx] <= bd_data;
      else        regs[bd_idx] <= bd_data;
    end
    if (reg_we) regs[reg_rw] <= reg_din;
    if (mem_we) mem[mem_ads] <= mem_din;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          op;
    logic [AW-1:0] addr;
    logic          wrap;
    logic [DW-1:0] data;
    logic [RW-1:0] rg;
    int            done_cyc;
  } exp_t;
  exp_t sb[$];
  int   last_acc = 0;

  task automatic preset(input logic to_mem, input logic [4:0] idx, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_mem = to_mem; bd_idx = idx; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Drive a command at a negedge, wait for ready, record expectation at acceptance.
  task automatic send(input logic op, input logic [RW-1:0] b, input logic [RW-1:0] r,
                      input logic [AW-1:0] o, input bit keep);
    exp_t e;
    logic [AW:0] s;
    bit ok;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = b; cmd_reg = r; cmd_off = o;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    s = {1'b0, regs[b][AW-1:0]} + {1'b0, o};
    e.op = op; e.addr = s[AW-1:0]; e.wrap = s[AW]; e.rg = r;
    e.data = op ? regs[r] : mem[s[AW-1:0]];
    e.done_cyc = cyc + (op ? 3 : 4);
    last_acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    cmd_op = ~op; cmd_base = ~b; cmd_reg = ~r; cmd_off = ~o;  // busy-time noise
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin chk("drain_timeout", sb.size(), 0); sb.delete(); end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (!cmd_ready) ;
    if (mem_we) begin
      if (sb.size() == 0 || sb[0].op != 1'b1) chk("spurious_mem_we", 1, 0);
      else begin
        chk("st_ads", mem_ads, sb[0].addr);
        chk("st_din", mem_din, sb[0].data);
        chk("st_rwe", reg_we, 0);
      end
    end
    if (reg_we) begin
      if (sb.size() == 0 || sb[0].op != 1'b0) chk("spurious_reg_we", 1, 0);
      else begin
        chk("ld_rw", reg_rw, sb[0].rg);
        chk("ld_din", reg_din, sb[0].data);
        chk("ld_ads", mem_ads, sb[0].addr);
      end
    end
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        chk("done_cyc", cyc, sb[0].done_cyc);
        chk("done_wrap", done_wrap, sb[0].wrap);
        chk("ready_busy", cmd_ready, 0);
        void'(sb.pop_front());
      end
    end
  end

  int a1, pre9;
  logic [DW-1:0] keep9;
  bit seen;

  initial begin
    for (int i = 0; i < 32; i++) begin regs[i] = '0; mem[i] = '0; end
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", {done, done_wrap}, 0);
    chk("rst_we", {reg_we, mem_we}, 0);
    chk("rst_idx", {reg_ra, reg_rb, reg_rw, mem_ads}, 0);
    chk("rst_data", mem_din ^ reg_din, 0);
    @(negedge clk); rst_n = 1'b1;

    preset(0, 3, 64'h4);
    preset(0, 7, 64'hDEAD_BEEF_0000_0001);
    send(1, 3, 7, 2, 0); drain();
    chk("mem6_after_st", mem[6], 64'hDEAD_BEEF_0000_0001);

    preset(1, 6, 64'h1234);
    send(0, 3, 9, 2, 0); drain();
    chk("r9_after_ld", regs[9], 64'h1234);

    preset(0, 3, 64'd30);
    send(1, 3, 7, 5, 0); drain();
    preset(0, 3, 64'hFFFF_FFFF_FFFF_FFFE);
    send(1, 3, 7, 5, 0); drain();
    chk("mem3_wrap", mem[3], 64'hDEAD_BEEF_0000_0001);

    // Held valid across two commands, with field noise during busy.
    preset(0, 3, 64'h4);
    send(0, 3, 10, 1, 1); a1 = last_acc;
    send(1, 3, 10, 9, 0);
    chk("b2b_load_spacing", last_acc - a1, 5);
    a1 = last_acc;
    send(1, 3, 7, 0, 0);
    chk("b2b_store_spacing", last_acc - a1, 4);
    drain();

    // Load into its own base register.
    preset(1, 7, 64'hCAFE_F00D);
    send(0, 3, 3, 3, 0); drain();
    chk("ld_into_base", regs[3], 64'hCAFE_F00D);

    for (int k = 0; k < 12; k++) begin
      preset(0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0);
      drain();
    end

    // Reset in WB of a load.
    preset(1, 8, 64'h5555_AAAA);
    preset(0, 4, 64'h8);
    preset(0, 9, 64'h9999);
    keep9 = regs[9];
    send(0, 4, 9, 0, 0);
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (reg_we) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("rst_saw_wb", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_we", {reg_we, mem_we}, 0);
    chk("rst_async_done", done, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_reg_kept", regs[9], keep9);
    rst_n = 1'b1;
    #1 chk("rst_rel_ready", cmd_ready, 1);
    repeat (6) @(negedge clk);
    chk("rst_no_done_after", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end
endmodule

// File: doc/unidade_ldst.md
# unidade_ldst

Load/store sequencer that drives the datapath's register file and data memory. Accepts one command at a time over a valid/ready handshake, reads the base register, forms the memory address as base + offset, and moves a 64-bit word memory→register (load) or register→memory (store). Acts as the initiator toward `registrador` and `memoria`, taking over the role the bench plays today; issues a one-cycle completion pulse per command.

## Interface
- DATA_W, 64, data word width (register and memory)
- ADDR_W, 5, memory address width
- REG_AW, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept (high only in IDLE)
- cmd_op  in  1  0 = load, 1 = store
- cmd_base  in  REG_AW  register holding base address
- cmd_reg  in  REG_AW  load destination / store source register
- cmd_off  in  ADDR_W  unsigned address offset
- done  out  1  one-cycle completion pulse
- done_wrap  out  1  valid with done: address sum overflowed ADDR_W
- reg_ra, reg_rb  out  REG_AW  register file read indices
- reg_douta, reg_doutb  in  DATA_W  register file read data (combinational)
- reg_rw  out  REG_AW  register file write index
- reg_we  out  1  register file write enable
- reg_din  out  DATA_W  register file write data
- mem_ads  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data, valid one cycle after mem_ads is presented

## Operation
- States: IDLE, ADDR, MEM, WB, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, capture op/base/reg/off → ADDR. Else stay.
- ADDR: reg_ra=base, reg_rb=reg. Register addr = (reg_douta[ADDR_W-1:0] + off) mod 2^ADDR_W, wrap flag = carry out, sdata = reg_doutb. Upper bits of reg_douta ignored. → MEM.
- MEM: mem_ads=addr. Store: mem_we=1, mem_din=sdata → DONE. Load: mem_we=0 → WB.
- WB (load only): mem_ads held = addr; reg_rw=reg, reg_din=mem_dout, reg_we=1 → DONE.
- DONE: done=1, done_wrap=wrap flag → IDLE.
- reg_we high only in WB; mem_we high only in MEM with op=store. Outputs not named for a state are 0.
- No register index is special; a load to cmd_base is legal (the base is already consumed in ADDR).
- Wrapped addresses are executed normally; done_wrap only reports.

## Timing
- Reset (async assert, sync release): state=IDLE, cmd_ready=1, done=0, done_wrap=0, reg_we=0, mem_we=0, all index/address/data outputs 0, captured fields 0.
- Accept edge = T0. Load: ADDR T0+1, MEM T0+2, WB T0+3, done in cycle T0+4. Store: done in cycle T0+3 (memory write at end of T0+2).
- Back-to-back: next command may be accepted in the cycle after done (IDLE); min spacing load 5, store 4 cycles.
- cmd_valid while not ready is ignored, not queued; the source must hold it.
- Reset mid-command: aborts immediately, no write enable asserted after rst_n falls, no done pulse.
- cmd_* fields sampled only on the accept edge; later changes have no effect.

## Structure
- Package `ldst_pkg`: state enum (IDLE, ADDR, MEM, WB, DONE), OP_LOAD=0/OP_STORE=1, default widths.
- Sub-module `soma_endereco`: ADDR_W-bit unsigned adder producing sum and carry; instantiated once in ADDR datapath.
- Remainder is a single FSM plus captured-command and addr/sdata registers.

## Test plan
- Store: R3=0x0000_0000_0000_0004, R7=0xDEAD_BEEF_0000_0001, cmd store base=3 reg=7 off=2 → mem_we=1 at ads 6 with din 0xDEAD_BEEF_0000_0001; done 3 cycles after accept, done_wrap=0.
- Load: mem[6]=0x1234, load base=3 reg=9 off=2 → reg_we=1, reg_rw=9, reg_din=0x1234 in WB; done 4 cycles after accept.
- Wrap: R3=30 (0x1E), off=5, store → mem_ads=3, done_wrap=1; upper bits of R3 set (0xFF..FE) give same ads.
- Handshake: cmd_valid held high across two commands → second accepted in cycle after first done; cmd_ready=0 in ADDR..DONE; field changes during busy ignored.
- Reset: assert rst_n=0 in WB of a load → reg_we drops asynchronously, no done, register unchanged; after release cmd_ready=1.
